// File: rtl/biquad_stream_mc.sv
// biquad_stream_mc: time-multiplexed multichannel direct-form-I biquad with valid/ready streams,
// round-to-nearest, output saturation, bypass and per-channel history.
module biquad_stream_mc #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 32,
  parameter int FRAC = 30,
  parameter int NUM_CH = 2,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter logic signed [COEF_W-1:0] A1_INIT = -2034054015,
  parameter logic signed [COEF_W-1:0] A2_INIT = 981124992,
  parameter logic signed [COEF_W-1:0] B0_INIT = 542364246,
  parameter logic signed [COEF_W-1:0] B1_INIT = -1073741824,
  parameter logic signed [COEF_W-1:0] B2_INIT = 542364246
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  input  logic              cfg_write,
  input  logic [2:0]        cfg_addr,
  input  logic [31:0]       cfg_data,
  output logic              bypass,
  output logic [15:0]       sat_count,
  output logic [31:0]       sample_count,
  output logic              err_ch
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W = PROD_W + 3;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
  typedef enum logic [1:0] {IDLE, MUL, SUM, OUT} state_t;
  state_t state_q, state_d;
  logic signed [COEF_W-1:0] a1_q, a1_d, a2_q, a2_d, b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic signed [DATA_W-1:0] x_q, x_d, out_data_q, out_data_d, y;
  logic [CH_W-1:0] ch_q, ch_d, out_ch_q, out_ch_d;
  logic signed [PROD_W-1:0] p_q [5];
  logic signed [PROD_W-1:0] p_d [5];
  logic signed [DATA_W-1:0] x1_q [NUM_CH];
  logic signed [DATA_W-1:0] x1_d [NUM_CH];
  logic signed [DATA_W-1:0] x2_q [NUM_CH];
  logic signed [DATA_W-1:0] x2_d [NUM_CH];
  logic signed [DATA_W-1:0] y1_q [NUM_CH];
  logic signed [DATA_W-1:0] y1_d [NUM_CH];
  logic signed [DATA_W-1:0] y2_q [NUM_CH];
  logic signed [DATA_W-1:0] y2_d [NUM_CH];
  logic bypass_q, bypass_d, err_ch_q, err_ch_d, clr_pend_q, clr_pend_d;
  logic [15:0] sat_count_q, sat_count_d;
  logic [31:0] sample_count_q, sample_count_d;
  logic signed [ACC_W-1:0] acc, acc_sh;
  logic clip, clr_req, clr_now, ch_bad, upd;
  always_comb begin
    acc = ACC_W'(p_q[0]) + ACC_W'(p_q[1]) + ACC_W'(p_q[2]) - ACC_W'(p_q[3]) - ACC_W'(p_q[4]) + RND;
    acc_sh = acc >>> FRAC;
    clip = !bypass_q && (acc_sh > Y_MAX || acc_sh < Y_MIN);
    y = bypass_q ? x_q : acc_sh > Y_MAX ? Y_MAX[DATA_W-1:0] :
        acc_sh < Y_MIN ? Y_MIN[DATA_W-1:0] : acc_sh[DATA_W-1:0];
    clr_req = cfg_write && cfg_addr == 3'd5 && cfg_data[1];
    clr_now = (clr_req || clr_pend_q) && state_q == IDLE;
    clr_pend_d = (clr_req || clr_pend_q) && state_q != IDLE;
    ch_bad = int'(in_ch) >= NUM_CH;
    upd = state_q == SUM;
    a1_d = cfg_write && cfg_addr == 3'd0 ? cfg_data[COEF_W-1:0] : a1_q;
    a2_d = cfg_write && cfg_addr == 3'd1 ? cfg_data[COEF_W-1:0] : a2_q;
    b0_d = cfg_write && cfg_addr == 3'd2 ? cfg_data[COEF_W-1:0] : b0_q;
    b1_d = cfg_write && cfg_addr == 3'd3 ? cfg_data[COEF_W-1:0] : b1_q;
    b2_d = cfg_write && cfg_addr == 3'd4 ? cfg_data[COEF_W-1:0] : b2_q;
    bypass_d = cfg_write && cfg_addr == 3'd5 ? cfg_data[0] : bypass_q;
    err_ch_d = (err_ch_q && !clr_now) || (state_q == IDLE && in_valid && ch_bad);
    // History shifts only for the channel whose result is produced this cycle
    for (int i = 0; i < NUM_CH; i++) begin
      x1_d[i] = clr_now ? '0 : (upd && int'(ch_q) == i) ? x_q : x1_q[i];
      x2_d[i] = clr_now ? '0 : (upd && int'(ch_q) == i) ? x1_q[i] : x2_q[i];
      y1_d[i] = clr_now ? '0 : (upd && int'(ch_q) == i) ? y : y1_q[i];
      y2_d[i] = clr_now ? '0 : (upd && int'(ch_q) == i) ? y1_q[i] : y2_q[i];
    end
    out_data_d = upd ? y : out_data_q;
    out_ch_d = upd ? ch_q : out_ch_q;
    sat_count_d = upd && clip && sat_count_q != 16'hFFFF ? sat_count_q + 16'd1 : sat_count_q;
    sample_count_d = state_q == OUT && out_ready ? sample_count_q + 32'd1 : sample_count_q;
    x_d = x_q;
    ch_d = ch_q;
    p_d = p_q;
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid && !ch_bad) begin
        x_d = $signed(in_data);
        ch_d = in_ch;
        state_d = MUL;
      end
      MUL: begin
        p_d[0] = PROD_W'(b0_q) * PROD_W'(x_q);
        p_d[1] = PROD_W'(b1_q) * PROD_W'(x1_q[ch_q]);
        p_d[2] = PROD_W'(b2_q) * PROD_W'(x2_q[ch_q]);
        p_d[3] = PROD_W'(a1_q) * PROD_W'(y1_q[ch_q]);
        p_d[4] = PROD_W'(a2_q) * PROD_W'(y2_q[ch_q]);
        state_d = SUM;
      end
      SUM: state_d = OUT;
      OUT: state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a1_q <= A1_INIT;
      a2_q <= A2_INIT;
      b0_q <= B0_INIT;
      b1_q <= B1_INIT;
      b2_q <= B2_INIT;
      x_q <= '0;
      ch_q <= '0;
      p_q <= '{default: '0};
      x1_q <= '{default: '0};
      x2_q <= '{default: '0};
      y1_q <= '{default: '0};
      y2_q <= '{default: '0};
      out_data_q <= '0;
      out_ch_q <= '0;
      bypass_q <= 1'b0;
      err_ch_q <= 1'b0;
      clr_pend_q <= 1'b0;
      sat_count_q <= '0;
      sample_count_q <= '0;
    end else begin
      state_q <= state_d;
      a1_q <= a1_d;
      a2_q <= a2_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
      b2_q <= b2_d;
      x_q <= x_d;
      ch_q <= ch_d;
      p_q <= p_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      bypass_q <= bypass_d;
      err_ch_q <= err_ch_d;
      clr_pend_q <= clr_pend_d;
      sat_count_q <= sat_count_d;
      sample_count_q <= sample_count_d;
    end
  end
  assign in_ready = state_q == IDLE && !reset;
  assign out_valid = state_q == OUT;
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
  assign bypass = bypass_q;
  assign sat_count = sat_count_q;
  assign sample_count = sample_count_q;
  assign err_ch = err_ch_q;
endmodule

// File: tb/tb_biquad_stream_mc.sv
// tb_biquad_stream_mc: directed vectors with hand-computed results for biquad_stream_mc (3 channels).
module tb_biquad_stream_mc;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1, cfg_write = 0;
  logic in_ready, out_valid, bypass, err_ch;
  logic [7:0] in_data = 0, out_data;
  logic [1:0] in_ch = 0, out_ch;
  logic [2:0] cfg_addr = 0;
  logic [31:0] cfg_data = 0, sample_count;
  logic [15:0] sat_count;
  int checks = 0, errors = 0, exp_n = 0;
  always #5 clk = ~clk;
  biquad_stream_mc #(.NUM_CH(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ch(in_ch), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .cfg_write(cfg_write), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .bypass(bypass), .sat_count(sat_count), .sample_count(sample_count), .err_ch(err_ch)
  );
  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [2:0] a, input logic [31:0] d);
    cfg_write = 1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_write = 0;
  endtask
  // Accept one sample, optionally writing clear_state on the SUM cycle, and wait for its result.
  task automatic send(input logic [1:0] ch, input int x, input bit clr_mid, output int y, output int och, output int lat);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    in_valid = 1; in_data = 8'(x); in_ch = ch;
    tick();
    in_valid = 0;
    lat = 1;
    if (clr_mid) begin
      tick();
      cfg_write = 1; cfg_addr = 3'd5; cfg_data = 32'd2;
      tick();
      cfg_write = 0;
      lat = 3;
    end
    while (!out_valid && lat < 10) begin tick(); lat++; end
    y = out_valid ? int'($signed(out_data)) : -999;
    och = int'(out_ch);
    if (out_valid && out_ready) tick();
  endtask
  task automatic run(input string tag, input logic [1:0] ch, input int x, input int exp, input bit clr_mid = 0);
    int y, och, lat;
    send(ch, x, clr_mid, y, och, lat);
    check({tag, "_y"}, y, exp);
    check({tag, "_ch"}, och, ch);
    check({tag, "_lat"}, lat, 3);
    exp_n++;
  endtask
  initial begin
    int y, och, lat, n;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    reset = 0;
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sat", sat_count, 0);
    check("rst_samples", sample_count, 0);
    check("rst_err", err_ch, 0);
    check("rst_bypass", bypass, 0);
    run("notch0", 0, 100, 51);
    run("notch1", 0, 0, -3);
    check("notch_samples", sample_count, exp_n);
    cfg(5, 32'd2); cfg(0, 0); cfg(1, 0); cfg(2, 32'h2000_0000); cfg(3, 0); cfg(4, 0);
    run("rnd_100", 0, 100, 50);
    run("rnd_3", 0, 3, 2);
    run("rnd_m3", 0, -3, -1);
    cfg(2, 32'h7FFF_FFFF);
    run("sat_pos", 0, 100, 127);
    check("sat_cnt1", sat_count, 1);
    run("sat_neg", 0, -100, -128);
    check("sat_cnt2", sat_count, 2);
    cfg(5, 32'd2); cfg(2, 32'h4000_0000); cfg(0, 32'hE000_0000);
    run("iso0", 0, 64, 64);
    run("iso1", 1, 0, 0);
    run("iso2", 0, 0, 32);
    out_ready = 0;
    send(1, 10, 0, y, och, lat);
    check("bp_y", y, 10);
    check("bp_lat", lat, 3);
    repeat (10) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", $signed(out_data), 10);
      check("bp_ch", out_ch, 1);
      check("bp_ready", in_ready, 0);
      check("bp_cnt", sample_count, exp_n);
    end
    out_ready = 1;
    tick();
    exp_n++;
    check("bp_release", sample_count, exp_n);
    check("bp_valid_off", out_valid, 0);
    tick();
    check("bp_once", sample_count, exp_n);
    run("clrmid_cur", 0, 0, 16, 1);
    run("clrmid_next", 0, 0, 0);
    in_valid = 1; in_ch = 2'd3; in_data = 8'd5;
    tick();
    in_valid = 0; in_ch = 0;
    check("err_set", err_ch, 1);
    check("err_ready", in_ready, 1);
    n = 0;
    repeat (6) begin if (out_valid) n++; tick(); end
    check("err_noout", n, 0);
    check("err_cnt", sample_count, exp_n);
    cfg(5, 32'd2);
    check("err_clr", err_ch, 0);
    in_valid = 1; in_ch = 0; in_data = 8'd100;
    tick();
    in_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    exp_n = 0;
    n = 0;
    repeat (6) begin if (out_valid) n++; tick(); end
    check("rstmul_noout", n, 0);
    check("rstmul_samples", sample_count, 0);
    check("rstmul_sat", sat_count, 0);
    run("init_b0", 0, 100, 51);
    cfg(5, 32'd1);
    check("byp_bit", bypass, 1);
    run("byp_pos", 0, 100, 100);
    run("byp_neg", 1, -128, -128);
    check("byp_sat", sat_count, 0);
    check("final_samples", sample_count, exp_n);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
